// File: rtl/alu_pkg.sv
// Shared ALU opcodes and sequencer state encoding.
package alu_pkg;

  // ALU operation codes understood by the shared 64-bit ALU
  localparam logic [3:0] ALU_AND   = 4'h0;
  localparam logic [3:0] ALU_OR    = 4'h1;
  localparam logic [3:0] ALU_ADD   = 4'h2;
  localparam logic [3:0] ALU_SUB   = 4'h6;
  localparam logic [3:0] ALU_PASSB = 4'h7;

  // Sequencer state codes; 2'd3 is unused and recovers to IDLE
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer. Every add is issued to the external
// shared ALU; this block only owns the ALU inputs while Busy is high.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNTW  = 7
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             Start,
  input  logic [WIDTH-1:0] MulA,
  input  logic [WIDTH-1:0] MulB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
  output logic [WIDTH-1:0] AluBusA,
  output logic [WIDTH-1:0] AluBusB,
  output logic [3:0]       AluCtrl,
  input  logic [WIDTH-1:0] AluBusW
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_product;
  logic             w_last;

  // Stop once no multiplier bits remain above the current one, or after WIDTH steps
  assign w_last = ((r_mplier >> 1) == '0) || (r_cnt == CNTW'(WIDTH - 1));

  assign Busy    = (r_state != ST_IDLE);
  assign Done    = (r_state == ST_DONE);
  assign Product = r_product;

  // State register
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and ALU request; buses are idle-safe outside RUN
  always_comb begin
    w_state_nxt = ST_IDLE;
    AluBusA     = '0;
    AluBusB     = '0;
    AluCtrl     = ALU_PASSB;
    case (r_state)
      ST_IDLE: w_state_nxt = Start ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        AluBusA     = r_mcand;
        AluBusB     = r_acc;
        AluCtrl     = r_mplier[0] ? ALU_ADD : ALU_PASSB;
        w_state_nxt = w_last ? ST_DONE : ST_RUN;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand load, per-iteration shift/accumulate, and result capture
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_mcand  <= MulA;
            r_mplier <= MulB;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        ST_RUN: begin
          r_acc    <= AluBusW;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNTW'(1);
          if (w_last) r_product <= AluBusW;
        end
        default: ;
      endcase
    end
  end

endmodule
